// File: rtl/alu_issue_arbiter.sv
// alu_issue_arbiter: two-requester round-robin issue into a single ALU issue
// register, with a short branch-resolution wait and a one-cycle redirect bubble.
module alu_issue_arbiter #(
  parameter int WIDTH = 32,
  parameter int OPW   = 8
) (
  input  logic             Clk,
  input  logic             Rest,
  input  logic             Req0Valid,
  input  logic [OPW-1:0]   Req0Op,
  input  logic [WIDTH-1:0] Req0Src1,
  input  logic [WIDTH-1:0] Req0Src2,
  input  logic [WIDTH-1:0] Req0Offset,
  input  logic [WIDTH-1:0] Req0Pc,
  input  logic [4:0]       Req0Rd,
  input  logic             Req0Pred,
  input  logic             Req0IsBr,
  output logic             Req0Ready,
  input  logic             Req1Valid,
  input  logic [OPW-1:0]   Req1Op,
  input  logic [WIDTH-1:0] Req1Src1,
  input  logic [WIDTH-1:0] Req1Src2,
  input  logic [WIDTH-1:0] Req1Offset,
  input  logic [WIDTH-1:0] Req1Pc,
  input  logic [4:0]       Req1Rd,
  input  logic             Req1Pred,
  input  logic             Req1IsBr,
  output logic             Req1Ready,
  input  logic             Flush,
  input  logic             JumpExvalue,
  output logic             AluValid,
  output logic [OPW-1:0]   AluOp,
  output logic [WIDTH-1:0] AluSrc1,
  output logic [WIDTH-1:0] AluSrc2,
  output logic [WIDTH-1:0] AluOffset,
  output logic [4:0]       AluRd,
  output logic [WIDTH-1:0] AluPc,
  output logic             AluPred,
  output logic             BrPending,
  output logic [15:0]      IssueCnt
);

  localparam logic [1:0] S_RUN    = 2'd0;
  localparam logic [1:0] S_BRWAIT = 2'd1;
  localparam logic [1:0] S_REDIR  = 2'd2;

  logic [1:0] state;
  logic       ptr;     // requester that wins when both are valid
  logic       brcnt;   // 0: branch sits in issue reg, 1: ALU result visible
  logic       issue;
  logic       issue_br;

  // Grant only while running and not flushing; ptr breaks ties.
  always_comb begin
    Req0Ready = 1'b0;
    Req1Ready = 1'b0;
    if (state == S_RUN && !Flush && !Rest) begin
      Req0Ready = Req0Valid & (~Req1Valid | ~ptr);
      Req1Ready = Req1Valid & (~Req0Valid |  ptr);
    end
  end

  assign issue     = Req0Ready | Req1Ready;
  assign issue_br  = Req1Ready ? Req1IsBr : Req0IsBr;
  assign BrPending = (state != S_RUN);

  // Control state: branch wait sequencing, round-robin pointer, issue count.
  always_ff @(posedge Clk or posedge Rest) begin
    if (Rest) begin
      state    <= S_RUN;
      ptr      <= 1'b0;
      brcnt    <= 1'b0;
      IssueCnt <= '0;
    end else if (Flush) begin
      // Flush wins over redirect and grants; ptr and count are left alone.
      state <= S_RUN;
      brcnt <= 1'b0;
    end else begin
      case (state)
        S_RUN: begin
          if (issue) begin
            ptr      <= Req0Ready;
            IssueCnt <= IssueCnt + 16'd1;
            if (issue_br) begin
              state <= S_BRWAIT;
              brcnt <= 1'b0;
            end
          end
        end
        S_BRWAIT: begin
          if (!brcnt) begin
            brcnt <= 1'b1;
          end else begin
            // Redirect indication only matters in the second wait cycle.
            brcnt <= 1'b0;
            state <= JumpExvalue ? S_REDIR : S_RUN;
          end
        end
        S_REDIR: state <= S_RUN;
        default: state <= S_RUN;
      endcase
    end
  end

  // Issue register: capture the granted payload, otherwise bubble with op 0.
  always_ff @(posedge Clk or posedge Rest) begin
    if (Rest) begin
      AluValid  <= 1'b0;
      AluOp     <= '0;
      AluSrc1   <= '0;
      AluSrc2   <= '0;
      AluOffset <= '0;
      AluRd     <= '0;
      AluPc     <= '0;
      AluPred   <= 1'b0;
    end else if (issue) begin
      AluValid  <= 1'b1;
      AluOp     <= Req1Ready ? Req1Op     : Req0Op;
      AluSrc1   <= Req1Ready ? Req1Src1   : Req0Src1;
      AluSrc2   <= Req1Ready ? Req1Src2   : Req0Src2;
      AluOffset <= Req1Ready ? Req1Offset : Req0Offset;
      AluRd     <= Req1Ready ? Req1Rd     : Req0Rd;
      AluPc     <= Req1Ready ? Req1Pc     : Req0Pc;
      AluPred   <= Req1Ready ? Req1Pred   : Req0Pred;
    end else begin
      // Covers flush and idle cycles alike; remaining fields hold.
      AluValid <= 1'b0;
      AluOp    <= '0;
    end
  end

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// Scoreboard bench for alu_issue_arbiter: directed request vectors push the
// expected issued payload; a negedge monitor pops and compares on AluValid.
module tb_alu_issue_arbiter;

  typedef struct packed {
    logic [7:0]  op;
    logic [31:0] s1;
    logic [31:0] s2;
    logic [31:0] off;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic        pred;
  } pl_t;

  logic        Clk = 1'b0;
  logic        Rest = 1'b0;
  logic        Req0Valid = 1'b0, Req1Valid = 1'b0;
  logic [7:0]  Req0Op = '0, Req1Op = '0;
  logic [31:0] Req0Src1 = '0, Req0Src2 = '0, Req0Offset = '0, Req0Pc = '0;
  logic [31:0] Req1Src1 = '0, Req1Src2 = '0, Req1Offset = '0, Req1Pc = '0;
  logic [4:0]  Req0Rd = '0, Req1Rd = '0;
  logic        Req0Pred = 1'b0, Req1Pred = 1'b0, Req0IsBr = 1'b0, Req1IsBr = 1'b0;
  logic        Req0Ready, Req1Ready;
  logic        Flush = 1'b0, JumpExvalue = 1'b0;
  logic        AluValid, AluPred, BrPending;
  logic [7:0]  AluOp;
  logic [31:0] AluSrc1, AluSrc2, AluOffset, AluPc;
  logic [4:0]  AluRd;
  logic [15:0] IssueCnt;

  int   n_chk  = 0;
  int   n_fail = 0;
  int   tag    = 0;
  bit   mon_en = 1'b1;
  pl_t  sb[$];

  alu_issue_arbiter #(.WIDTH(32), .OPW(8)) dut (
    .Clk(Clk), .Rest(Rest),
    .Req0Valid(Req0Valid), .Req0Op(Req0Op), .Req0Src1(Req0Src1), .Req0Src2(Req0Src2),
    .Req0Offset(Req0Offset), .Req0Pc(Req0Pc), .Req0Rd(Req0Rd), .Req0Pred(Req0Pred),
    .Req0IsBr(Req0IsBr), .Req0Ready(Req0Ready),
    .Req1Valid(Req1Valid), .Req1Op(Req1Op), .Req1Src1(Req1Src1), .Req1Src2(Req1Src2),
    .Req1Offset(Req1Offset), .Req1Pc(Req1Pc), .Req1Rd(Req1Rd), .Req1Pred(Req1Pred),
    .Req1IsBr(Req1IsBr), .Req1Ready(Req1Ready),
    .Flush(Flush), .JumpExvalue(JumpExvalue),
    .AluValid(AluValid), .AluOp(AluOp), .AluSrc1(AluSrc1), .AluSrc2(AluSrc2),
    .AluOffset(AluOffset), .AluRd(AluRd), .AluPc(AluPc), .AluPred(AluPred),
    .BrPending(BrPending), .IssueCnt(IssueCnt)
  );

  always #5 Clk = ~Clk;

  function automatic void chk(string nm, logic [159:0] act, logic [159:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  // Monitor: every ALU-valid cycle must match the oldest expected issue.
  always @(negedge Clk) begin
    if (mon_en && !Rest) begin
      if (AluValid) begin
        if (sb.size() == 0) begin
          chk("unexpected_issue", 160'd1, 160'd0);
        end else begin
          pl_t e;
          e = sb.pop_front();
          chk("alu_payload",
              {AluOp, AluSrc1, AluSrc2, AluOffset, AluRd, AluPc, AluPred}, e);
        end
      end else begin
        chk("alu_bubble_op", AluOp, 8'h00);
      end
    end
  end

  // One cycle of directed stimulus with hand-computed expected grants.
  task automatic step(input logic v0, v1, b0, b1, fl, jx, eg0, eg1, ebp);
    pl_t p0, p1;
    @(posedge Clk); #1;
    tag++;
    p0.op = 8'h01 + 8'(tag); p0.s1 = 32'h1000_0000 + tag; p0.s2 = 32'h2000_0000 + tag;
    p0.off = 32'h3000_0000 + tag; p0.rd = 5'(tag); p0.pc = 32'h4000_0000 + tag;
    p0.pred = tag[0];
    p1.op = 8'h80 | 8'(tag); p1.s1 = 32'h5000_0000 + tag; p1.s2 = 32'h6000_0000 + tag;
    p1.off = 32'h7000_0000 + tag; p1.rd = ~5'(tag); p1.pc = 32'h8000_0000 + tag;
    p1.pred = ~tag[0];
    Req0Valid = v0; Req0IsBr = b0; Req0Op = p0.op; Req0Src1 = p0.s1; Req0Src2 = p0.s2;
    Req0Offset = p0.off; Req0Rd = p0.rd; Req0Pc = p0.pc; Req0Pred = p0.pred;
    Req1Valid = v1; Req1IsBr = b1; Req1Op = p1.op; Req1Src1 = p1.s1; Req1Src2 = p1.s2;
    Req1Offset = p1.off; Req1Rd = p1.rd; Req1Pc = p1.pc; Req1Pred = p1.pred;
    Flush = fl; JumpExvalue = jx;
    @(negedge Clk);
    chk("ready0", Req0Ready, eg0);
    chk("ready1", Req1Ready, eg1);
    chk("brpending", BrPending, ebp);
    if (eg0) sb.push_back(p0);
    else if (eg1) sb.push_back(p1);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    // Asynchronous reset with requests pending: everything quiet.
    #1 Rest = 1'b1; Req0Valid = 1'b1; Req1Valid = 1'b1;
    #2;
    chk("rst_ready0", Req0Ready, 1'b0);
    chk("rst_ready1", Req1Ready, 1'b0);
    chk("rst_outs", {AluValid, AluOp, AluSrc1, AluPc, AluRd, AluPred, BrPending, IssueCnt}, '0);
    Req0Valid = 1'b0; Req1Valid = 1'b0;
    #4 Rest = 1'b0;

    // Round robin from reset: 0,1,0,1.
    step(1,1,0,0,0,0, 1,0, 0);
    step(1,1,0,0,0,0, 0,1, 0);
    step(1,1,0,0,0,0, 1,0, 0);
    step(1,1,0,0,0,0, 0,1, 0);
    step(0,0,0,0,0,0, 0,0, 0);
    chk("cnt_after_rr", IssueCnt, 16'd4);

    // Branch from req0, no redirect; JumpExvalue in wait cycle 1 is ignored.
    step(1,1,1,0,0,0, 1,0, 0);
    step(1,1,0,0,0,1, 0,0, 1);
    step(1,1,0,0,0,0, 0,0, 1);
    step(1,1,0,0,0,0, 0,1, 0);

    // Branch from req0 with redirect: extra bubble cycle.
    step(1,1,1,0,0,0, 1,0, 0);
    step(1,1,0,0,0,0, 0,0, 1);
    step(1,1,0,0,0,1, 0,0, 1);
    step(1,1,0,0,0,0, 0,0, 1);
    step(1,1,0,0,0,0, 0,1, 0);

    // Flush in RUN blocks grants and holds ptr (ptr=1 after the next grant).
    step(1,1,0,0,0,0, 1,0, 0);
    step(1,1,0,0,1,0, 0,0, 0);
    // Branch from req1 (ptr held at 1), flushed in wait cycle 1; redirect ignored.
    step(1,1,0,1,0,0, 0,1, 0);
    step(1,1,0,0,1,0, 0,0, 1);
    step(1,1,0,0,0,1, 1,0, 0);
    step(0,0,0,0,0,0, 0,0, 0);
    chk("cnt_after_flush", IssueCnt, 16'd11);

    // Reset pulsed between edges during branch wait cycle 2.
    step(0,1,0,1,0,0, 0,1, 0);
    step(1,1,0,0,0,0, 0,0, 1);
    @(posedge Clk); #1;
    Req0Valid = 1'b1; Req1Valid = 1'b1; Req0IsBr = 1'b0; Req1IsBr = 1'b0;
    #1 Rest = 1'b1;
    #1;
    chk("mid_rst_ready", {Req0Ready, Req1Ready}, 2'b00);
    chk("mid_rst_outs", {AluValid, AluOp, AluSrc1, AluSrc2, AluOffset, AluRd, AluPc, AluPred,
                         BrPending, IssueCnt}, '0);
    Req0Valid = 1'b0; Req1Valid = 1'b0;
    #1 Rest = 1'b0;
    @(negedge Clk);
    step(1,1,0,0,0,0, 1,0, 0);
    step(1,1,0,0,0,0, 0,1, 0);
    step(0,0,0,0,0,0, 0,0, 0);
    chk("cnt_after_rst", IssueCnt, 16'd2);

    // Counter wrap: fresh reset, 65535 back-to-back issues, then one more.
    @(posedge Clk); #1 Rest = 1'b1; #2 Rest = 1'b0;
    mon_en = 1'b0;
    @(posedge Clk); #1;
    Req0Valid = 1'b1; Req0IsBr = 1'b0; Req1Valid = 1'b0; Flush = 1'b0; JumpExvalue = 1'b0;
    repeat (65535) @(posedge Clk);
    #1 Req0Valid = 1'b0;
    @(negedge Clk); #1 mon_en = 1'b1;
    chk("cnt_ffff", IssueCnt, 16'hFFFF);
    step(1,0,0,0,0,0, 1,0, 0);
    step(0,0,0,0,0,0, 0,0, 0);
    chk("cnt_wrap", IssueCnt, 16'h0000);

    step(0,0,0,0,0,0, 0,0, 0);
    chk("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
